// File: rtl/mux_n_to_1_stream.sv
// N-channel stream multiplexer with a registered output stage.
// Two arbitration modes: direct channel select, or round-robin over the
// valid channels, starting after the most recently granted one.
module mux_n_to_1_stream #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic [SEL_W-1:0] w_rr_chosen;
    logic             w_rr_hit;
    logic [SEL_W-1:0] w_chosen;
    logic             w_hit;
    logic [WIDTH-1:0] w_chosen_data;
    logic [N_CH-1:0]  w_ready;
    logic             w_xfer;

    // The output register can take a beat when empty or draining this cycle.
    assign w_load_en = !r_valid || out_ready;

    // Round-robin search: walk offsets from N_CH down to 1 so the nearest
    // valid channel after rr_ptr is the last (and winning) assignment.
    always_comb begin
        logic [SEL_W:0] sum;
        sum         = '0;
        w_rr_chosen = '0;
        w_rr_hit    = |in_valid;
        for (int k = N_CH; k >= 1; k--) begin
            sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(N_CH))
                sum = sum - (SEL_W+1)'(N_CH);
            if (in_valid[sum[SEL_W-1:0]])
                w_rr_chosen = sum[SEL_W-1:0];
        end
    end

    // Pick the source channel for the current mode; out-of-range sel never hits.
    always_comb begin
        w_chosen = sel;
        w_hit    = ({1'b0, sel} < (SEL_W+1)'(N_CH));
        if (mode) begin
            w_chosen = w_rr_chosen;
            w_hit    = w_rr_hit;
        end
    end

    // Data select by compare loop so an out-of-range index yields zeros, not X.
    always_comb begin
        w_chosen_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_chosen == SEL_W'(i))
                w_chosen_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // One-hot ready toward the chosen channel; held low during reset.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_ready[i] = w_load_en && w_hit && (w_chosen == SEL_W'(i)) && !rst;
        end
    end

    assign w_xfer   = |(in_valid & w_ready);
    assign in_ready = w_ready;

    // Output register and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_ch     <= '0;
            r_valid  <= 1'b0;
            r_rr_ptr <= SEL_W'(N_CH - 1);
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_data  <= w_chosen_data;
                r_ch    <= w_chosen;
                r_valid <= 1'b1;
                if (mode)
                    r_rr_ptr <= w_chosen;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Bench for mux_n_to_1_stream: a 4-channel and a 3-channel instance share
// stimulus; a queue-free reference model predicts every cycle's outputs.
module tb_mux_n_to_1_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;

    logic [3:0]  rdy4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        ov4;
    logic [2:0]  rdy3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ov3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_n_to_1_stream #(.WIDTH(8), .N_CH(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
        .out_data(od4), .out_ch(oc4), .out_valid(ov4), .out_ready(out_ready)
    );

    mux_n_to_1_stream #(.WIDTH(8), .N_CH(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
        .out_data(od3), .out_ch(oc3), .out_valid(ov3), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant rule: direct returns sel if in range; round-robin
    // returns the first valid channel after ptr, modulo n. -1 means no hit.
    function automatic int grant(input logic md, input logic [1:0] s,
                                 input logic [3:0] v, input int ptr, input int n);
        if (!md) return (int'(s) < n) ? int'(s) : -1;
        for (int k = 1; k <= n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    // Model state for both instances.
    logic       m4_v, m3_v;
    logic [7:0] m4_d, m3_d;
    int         m4_c, m3_c, m4_p, m3_p;
    int         g4, g3;
    logic [3:0] er4;
    logic [2:0] er3;

    always_comb begin
        g4  = grant(mode, sel, in_valid, m4_p, 4);
        g3  = grant(mode, sel, {1'b0, in_valid[2:0]}, m3_p, 3);
        er4 = (!rst && (!m4_v || out_ready) && g4 >= 0) ? 4'(4'b1 << g4) : 4'b0;
        er3 = (!rst && (!m3_v || out_ready) && g3 >= 0) ? 3'(3'b1 << g3) : 3'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4_v <= 1'b0; m4_d <= 8'h0; m4_c <= 0; m4_p <= 3;
            m3_v <= 1'b0; m3_d <= 8'h0; m3_c <= 0; m3_p <= 2;
        end else begin
            if (!m4_v || out_ready) begin
                if (g4 >= 0 && in_valid[g4]) begin
                    m4_v <= 1'b1; m4_d <= in_data[g4*8 +: 8]; m4_c <= g4;
                    if (mode) m4_p <= g4;
                end else m4_v <= 1'b0;
            end
            if (!m3_v || out_ready) begin
                if (g3 >= 0 && in_valid[g3]) begin
                    m3_v <= 1'b1; m3_d <= in_data[g3*8 +: 8]; m3_c <= g3;
                    if (mode) m3_p <= g3;
                end else m3_v <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m4_valid", 32'(ov4), 32'(m4_v));
        chk("m4_data",  32'(od4), 32'(m4_d));
        chk("m4_ch",    32'(oc4), 32'(m4_c));
        chk("m4_ready", 32'(rdy4), 32'(er4));
        chk("m3_valid", 32'(ov3), 32'(m3_v));
        chk("m3_data",  32'(od3), 32'(m3_d));
        chk("m3_ch",    32'(oc3), 32'(m3_c));
        chk("m3_ready", 32'(rdy3), 32'(er3));
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = 32'h0;
        in_valid = 4'h0; out_ready = 1'b0;
        tick; tick;
        chk("rst_valid", 32'(ov4), 32'h0);
        chk("rst_ready", 32'(rdy4), 32'h0);
        rst = 1'b0;

        // Direct mode, sel stepping through all channels.
        in_data = 32'h44332211; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick;
            chk("dir_valid", 32'(ov4), 32'h1);
            chk("dir_data",  32'(od4), 32'(8'h11 * (i + 1)));
            chk("dir_ch",    32'(oc4), 32'(i));
        end

        // Round-robin, all channels valid: 0,1,2,3,0,1,2,3 without bubbles.
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("rr_valid", 32'(ov4), 32'h1);
            chk("rr_ch",    32'(oc4), 32'(i % 4));
        end

        // Wrap and skip: only 1 and 3 valid, pointer at 3.
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1 chk("skip_rdy02", 32'(rdy4 & 4'b0101), 32'h0);
            tick;
            chk("skip_ch", 32'(oc4), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: hold three cycles, then load while draining.
        in_valid = 4'hF; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", 32'(rdy4), 32'h0);
            tick;
            chk("bp_ch",   32'(oc4), 32'd3);
            chk("bp_data", 32'(od4), 32'h44);
            chk("bp_valid", 32'(ov4), 32'h1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(rdy4), 32'h1);
        tick;
        chk("bp_next_ch",   32'(oc4), 32'd0);
        chk("bp_next_data", 32'(od4), 32'h11);

        // Reset while a beat is held: cleared immediately, ready low.
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ov4), 32'h0);
        chk("mid_rst_data",  32'(od4), 32'h0);
        chk("mid_rst_ch",    32'(oc4), 32'h0);
        chk("mid_rst_ready", 32'(rdy4), 32'h0);
        chk("mid_rst_ready3", 32'(rdy3), 32'h0);
        tick;
        rst = 1'b0; out_ready = 1'b1;
        tick;
        chk("post_rst_ch",    32'(oc4), 32'd0);
        chk("post_rst_valid", 32'(ov4), 32'h1);

        // Out-of-range select on the 3-channel instance.
        mode = 1'b0; sel = 2'd3;
        #1 chk("oor_ready3", 32'(rdy3), 32'h0);
        tick;
        chk("oor_valid3", 32'(ov3), 32'h0);
        tick;
        chk("oor_known3", 32'($isunknown({od3, oc3, ov3, rdy3})), 32'h0);
        chk("oor_data4",  32'(od4), 32'h44);
        sel = 2'd2;
        tick;
        chk("in_range3_data", 32'(od3), 32'h33);
        chk("in_range3_ch",   32'(oc3), 32'd2);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
